// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: bus width, reset vector,
// state encoding and the layout of one instruction-queue entry.
package fetch_unit_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam logic [ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'hbfc00000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_BUS-1:0] pc;
    logic [31:0]         inst;
    logic                adel;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-cache read port and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  redirect_en;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  icache_read_en;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_ready;
  logic [31:0]           icache_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [31:0]           out_inst;
  logic                  out_adel;

  modport master (
    input  redirect_en, redirect_pc, icache_ready, icache_data, out_ready,
    output icache_read_en, icache_addr, out_valid, out_pc, out_inst, out_adel
  );

  modport slave (
    output redirect_en, redirect_pc, icache_ready, icache_data, out_ready,
    input  icache_read_en, icache_addr, out_valid, out_pc, out_inst, out_adel
  );
endinterface

// File: rtl/fetch_unit_fetch_queue.sv
// In-order instruction queue: synchronous FIFO with flush and a combinational head read.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // A push alongside a flush lands in slot 0 of the emptied queue.
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? CW'(1) : '0;
      if (push) mem[0] <= wr_data;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues cache reads, handles
// redirects and misaligned fetches, and queues fetched words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ADDR_BUS,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned           QUEUE_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc, pending_pc;
  logic                  miss_busy;
  logic                  read_en, full, empty;
  logic                  to_drain, misaligned, run_push, adel_push, push, pop;
  fetch_entry_t          wr_entry, head;
  logic [ENTRY_W-1:0]    head_raw;

  always_comb begin
    read_en = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN:   read_en = !full || miss_busy;
        ST_DRAIN: read_en = 1'b1;
        default:  read_en = 1'b0;
      endcase
    end
  end

  assign to_drain   = miss_busy || (state == ST_DRAIN);
  assign misaligned = |bus.redirect_pc[1:0];
  assign run_push   = (state == ST_RUN) && read_en && bus.icache_ready && !bus.redirect_en;
  assign adel_push  = bus.redirect_en && !to_drain && misaligned;
  assign push       = run_push || adel_push;
  assign pop        = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_entry = '{pc: pc, inst: bus.icache_data, adel: 1'b0};
    if (adel_push) wr_entry = '{pc: bus.redirect_pc, inst: '0, adel: 1'b1};
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_en),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head_raw),
    .full    (full),
    .empty   (empty)
  );

  assign head               = fetch_entry_t'(head_raw);
  assign bus.icache_read_en = read_en;
  assign bus.icache_addr    = pc;
  assign bus.out_valid      = !empty && !bus.redirect_en;
  assign bus.out_pc         = head.pc;
  assign bus.out_inst       = head.inst;
  assign bus.out_adel       = head.adel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      pending_pc <= '0;
      miss_busy  <= 1'b0;
    end else begin
      if (bus.icache_ready) miss_busy <= 1'b0;
      else if (read_en)     miss_busy <= 1'b1;

      if (bus.redirect_en) begin
        if (to_drain) begin
          pending_pc <= bus.redirect_pc;
          state      <= ST_DRAIN;
        end else if (misaligned) begin
          state <= ST_HALT;
        end else begin
          pc    <= bus.redirect_pc;
          state <= ST_RUN;
        end
      end else begin
        case (state)
          ST_RUN:   if (run_push) pc <= pc + ADDR_WIDTH'(4);
          // The refill word for the old PC is discarded before restarting.
          ST_DRAIN: if (bus.icache_ready) begin
                      pc    <= pending_pc;
                      state <= ST_RUN;
                    end
          default:  ;
        endcase
      end
    end
  end

endmodule
